// File: rtl/logic_unit_if.sv
// logic_unit_if: input/output handshake bundle for the pipelined logic unit
interface logic_unit_if #(parameter int WIDTH = 16);
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       op;
  logic             use_acc;
  logic             acc_clr;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             zero;
  logic             all_ones;
  logic             parity;
  logic [WIDTH-1:0] acc;
  modport master (
    output in_valid, op, use_acc, acc_clr, a, b, out_ready,
    input  in_ready, out_valid, result, zero, all_ones, parity, acc
  );
  modport slave (
    input  in_valid, op, use_acc, acc_clr, a, b, out_ready,
    output in_ready, out_valid, result, zero, all_ones, parity, acc
  );
endinterface

// File: rtl/logic_unit_pipe.sv
// logic_unit_pipe: 2-stage opcode-selected bitwise logic unit with backpressure and feedback accumulator
module logic_unit_pipe #(
  parameter int WIDTH  = 16,
  parameter bit ACC_EN = 1
) (
  input logic         clk,
  input logic         rst_n,
  logic_unit_if.slave bus
);
  logic             s1_valid, out_valid_q, zero_q, ones_q, par_q;
  logic             s2_free, in_ready, accept;
  logic [WIDTH-1:0] s1_data, result_q, acc_q, op_a, base, f;
  assign s2_free  = !out_valid_q || bus.out_ready;
  assign in_ready = rst_n && (!s1_valid || s2_free);
  assign accept   = bus.in_valid && in_ready;
  // a same-cycle clear zeroes the accumulator operand, but the op result still wins the acc write
  assign op_a = (ACC_EN && bus.use_acc) ? (bus.acc_clr ? '0 : acc_q) : bus.a;
  // upper opcode bit inverts the base function: NAND/NOR/XNOR, and NOT(NOT A) = PASS A
  assign base = bus.op[1:0] == 2'd0 ? op_a & bus.b :
                bus.op[1:0] == 2'd1 ? op_a | bus.b :
                bus.op[1:0] == 2'd2 ? op_a ^ bus.b : ~op_a;
  assign f = bus.op[2] ? ~base : base;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid    <= 1'b0;
      s1_data     <= '0;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      zero_q      <= 1'b0;
      ones_q      <= 1'b0;
      par_q       <= 1'b0;
      acc_q       <= '0;
    end else begin
      if (accept) begin
        s1_valid <= 1'b1;
        s1_data  <= f;
      end else if (s2_free) begin
        s1_valid <= 1'b0;
      end
      if (s2_free) begin
        out_valid_q <= s1_valid;
        if (s1_valid) begin
          result_q <= s1_data;
          zero_q   <= ~|s1_data;
          ones_q   <= &s1_data;
          par_q    <= ^s1_data;
        end
      end
      if (ACC_EN) acc_q <= accept ? f : bus.acc_clr ? '0 : acc_q;
    end
  end
  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.result    = result_q;
  assign bus.zero      = zero_q;
  assign bus.all_ones  = ones_q;
  assign bus.parity    = par_q;
  assign bus.acc       = acc_q;
endmodule

// File: tb/tb_logic_unit_pipe.sv
// tb_logic_unit_pipe: scoreboard bench for the pipelined logic unit (16-bit with acc, 8-bit without)
module tb_logic_unit_pipe;
  typedef struct {
    logic [15:0] r;
    int          c;
  } ent_t;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int n_tests = 0;
  int n_fail = 0;
  int cyc = 0;
  int n_acc = 0;
  bit chk_lat = 1'b0;
  logic [15:0] acc_m = '0;
  ent_t q[$];
  logic [18:0] got[$];
  logic [15:0] sweep_exp [8] = '{16'hF000, 16'hFFF0, 16'h0FF0, 16'h0F0F, 16'h0FFF, 16'h000F, 16'hF00F, 16'hF0F0};
  logic [15:0] bp_exp [4] = '{16'hF000, 16'hFFF0, 16'h0FF0, 16'h0F0F};
  logic [15:0] chain_exp [4] = '{16'h000F, 16'h00F0, 16'h0030, 16'h0101};
  logic_unit_if #(.WIDTH(16)) u ();
  logic_unit_if #(.WIDTH(8)) u8 ();
  logic_unit_pipe #(.WIDTH(16), .ACC_EN(1'b1)) dut (.clk(clk), .rst_n(rst_n), .bus(u.slave));
  logic_unit_pipe #(.WIDTH(8), .ACC_EN(1'b0)) dut8 (.clk(clk), .rst_n(rst_n), .bus(u8.slave));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask
  function automatic logic [15:0] model(input logic [2:0] o, input logic [15:0] x, input logic [15:0] y);
    case (o)
      3'd0: return x & y;
      3'd1: return x | y;
      3'd2: return x ^ y;
      3'd3: return ~x;
      3'd4: return ~(x & y);
      3'd5: return ~(x | y);
      3'd6: return ~(x ^ y);
      default: return x;
    endcase
  endfunction
  // samples just before each rising edge, when bench inputs and DUT state are settled
  initial forever begin
    logic [15:0] oa, r;
    ent_t e;
    @(negedge clk);
    #4;
    cyc++;
    if (rst_n) begin
      chk("acc", u.acc, acc_m);
      if (u.out_valid && u.out_ready) begin
        if (q.size() == 0) chk("sb_underflow", 1, 0);
        else begin
          e = q.pop_front();
          chk("result", u.result, e.r);
          chk("zero", u.zero, e.r == 16'h0);
          chk("all_ones", u.all_ones, &e.r);
          chk("parity", u.parity, ^e.r);
          if (chk_lat) chk("latency", cyc - e.c, 2);
          got.push_back({u.result, u.zero, u.all_ones, u.parity});
        end
      end
      if (u.in_valid && u.in_ready) begin
        oa = u.use_acc ? (u.acc_clr ? 16'h0 : acc_m) : u.a;
        r = model(u.op, oa, u.b);
        q.push_back('{r, cyc});
        acc_m = r;
        n_acc++;
      end else if (u.acc_clr) acc_m = '0;
    end
  end
  task automatic send(input logic [2:0] o, input logic ua, input logic ac, input logic [15:0] av, input logic [15:0] bv);
    int n = 0;
    @(negedge clk);
    u.in_valid = 1'b1;
    u.op = o;
    u.use_acc = ua;
    u.acc_clr = ac;
    u.a = av;
    u.b = bv;
    #3;
    while (!u.in_ready && n < 100) begin
      @(negedge clk);
      #3;
      n++;
    end
    if (n >= 100) chk("send_timeout", 0, 1);
    @(posedge clk);
  endtask
  task automatic idle();
    @(negedge clk);
    u.in_valid = 1'b0;
    u.acc_clr = 1'b0;
    u.use_acc = 1'b0;
  endtask
  task automatic drain();
    int n = 0;
    while (q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("drain", q.size(), 0);
    repeat (2) @(negedge clk);
  endtask
  initial begin
    logic [15:0] r0;
    int base;
    {u.in_valid, u.op, u.use_acc, u.acc_clr, u.a, u.b} = '0;
    u.out_ready = 1'b1;
    {u8.in_valid, u8.op, u8.use_acc, u8.acc_clr, u8.a, u8.b} = '0;
    u8.out_ready = 1'b1;
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_out_valid", u.out_valid, 0);
    chk("rst_result", u.result, 0);
    chk("rst_flags", {u.zero, u.all_ones, u.parity}, 0);
    chk("rst_acc", u.acc, 0);
    chk("rst_in_ready", u.in_ready, 0);
    rst_n = 1'b1;
    #1 chk("rel_in_ready", u.in_ready, 1);
    // opcode sweep, back-to-back
    chk_lat = 1'b1;
    got.delete();
    for (int i = 0; i < 8; i++) send(3'(i), 1'b0, 1'b0, 16'hF0F0, 16'hFF00);
    idle();
    drain();
    chk("sweep_cnt", got.size(), 8);
    if (got.size() == 8) for (int i = 0; i < 8; i++) chk($sformatf("sweep_op%0d", i), got[i][18:3], sweep_exp[i]);
    // flags
    got.delete();
    send(3'd2, 1'b0, 1'b0, 16'h1234, 16'h1234);
    send(3'd6, 1'b0, 1'b0, 16'h1234, 16'h1234);
    send(3'd7, 1'b0, 1'b0, 16'h0001, 16'h0000);
    idle();
    drain();
    chk("flag_cnt", got.size(), 3);
    if (got.size() == 3) begin
      chk("flag_xor", got[0], {16'h0000, 3'b100});
      chk("flag_xnor", got[1], {16'hFFFF, 3'b010});
      chk("flag_pass", got[2], {16'h0001, 3'b001});
    end
    // accumulator chain
    got.delete();
    @(negedge clk);
    u.acc_clr = 1'b1;
    @(negedge clk);
    u.acc_clr = 1'b0;
    send(3'd1, 1'b1, 1'b0, 16'hDEAD, 16'h000F);
    send(3'd2, 1'b1, 1'b0, 16'hBEEF, 16'h00FF);
    send(3'd0, 1'b1, 1'b0, 16'h1111, 16'h0030);
    send(3'd1, 1'b1, 1'b1, 16'h2222, 16'h0101);
    idle();
    drain();
    chk("chain_cnt", got.size(), 4);
    if (got.size() == 4) for (int i = 0; i < 4; i++) chk($sformatf("chain%0d", i), got[i][18:3], chain_exp[i]);
    chk("chain_acc", u.acc, 16'h0101);
    // backpressure: pipe holds two ops, third waits
    chk_lat = 1'b0;
    got.delete();
    base = n_acc;
    @(negedge clk);
    u.out_ready = 1'b0;
    fork
      for (int i = 0; i < 4; i++) send(3'(i), 1'b0, 1'b0, 16'hF0F0, 16'hFF00);
      begin
        repeat (4) @(negedge clk);
        #2 r0 = u.result;
        repeat (4) @(negedge clk);
        #2;
        chk("bp_in_ready", u.in_ready, 0);
        chk("bp_accepts", n_acc - base, 2);
        chk("bp_out_valid", u.out_valid, 1);
        chk("bp_hold", u.result, r0);
        chk("bp_first", u.result, 16'hF000);
        u.out_ready = 1'b1;
      end
    join
    idle();
    drain();
    chk("bp_cnt", got.size(), 4);
    if (got.size() == 4) for (int i = 0; i < 4; i++) chk($sformatf("bp%0d", i), got[i][18:3], bp_exp[i]);
    // random traffic against the model
    for (int i = 0; i < 10000; i++) begin
      @(negedge clk);
      u.out_ready = $urandom_range(0, 3) != 0;
      u.in_valid = $urandom_range(0, 1) == 1;
      u.op = 3'($urandom_range(0, 7));
      u.use_acc = $urandom_range(0, 1) == 1;
      u.acc_clr = $urandom_range(0, 7) == 0;
      u.a = 16'($urandom);
      u.b = 16'($urandom);
    end
    @(negedge clk);
    u.out_ready = 1'b1;
    idle();
    drain();
    // reset mid-stream
    send(3'd7, 1'b0, 1'b0, 16'hABCD, 16'h0000);
    idle();
    drain();
    chk("pre_rst_acc", u.acc, 16'hABCD);
    @(negedge clk);
    u.out_ready = 1'b0;
    send(3'd0, 1'b0, 1'b0, 16'h1234, 16'h5678);
    send(3'd1, 1'b0, 1'b0, 16'h1234, 16'h5678);
    @(negedge clk);
    u.in_valid = 1'b0;
    chk("pre_rst_valid", u.out_valid, 1);
    rst_n = 1'b0;
    q.delete();
    acc_m = '0;
    #1;
    chk("mid_rst_out_valid", u.out_valid, 0);
    chk("mid_rst_acc", u.acc, 0);
    chk("mid_rst_in_ready", u.in_ready, 0);
    @(negedge clk);
    rst_n = 1'b1;
    u.out_ready = 1'b1;
    #1 chk("post_rst_in_ready", u.in_ready, 1);
    chk_lat = 1'b1;
    got.delete();
    send(3'd2, 1'b0, 1'b0, 16'h00FF, 16'h0F0F);
    idle();
    drain();
    chk("post_rst_cnt", got.size(), 1);
    if (got.size() == 1) chk("post_rst_result", got[0][18:3], 16'h0FF0);
    // 8-bit unit without accumulator
    @(negedge clk);
    u8.in_valid = 1'b1;
    u8.use_acc = 1'b1;
    u8.acc_clr = 1'b1;
    u8.op = 3'd0;
    u8.a = 8'h3C;
    u8.b = 8'h0F;
    #3 chk("w8_in_ready", u8.in_ready, 1);
    @(negedge clk);
    u8.in_valid = 1'b0;
    u8.acc_clr = 1'b0;
    chk("w8_acc_s1", u8.acc, 8'h00);
    @(negedge clk);
    chk("w8_out_valid", u8.out_valid, 1);
    chk("w8_result", u8.result, 8'h0C);
    chk("w8_acc", u8.acc, 8'h00);
    chk("w8_flags", {u8.zero, u8.all_ones, u8.parity}, 3'b000);
    @(negedge clk);
    chk("w8_retired", u8.out_valid, 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
